// File: rtl/axis_tx_frame_buffer.sv
// Store-and-forward AXIS TX frame buffer: releases only fully stored frames,
// drops frames over MAX_BYTES and zero-pads runts up to MIN_BYTES.
module axis_tx_frame_buffer #(
  parameter int unsigned DEPTH       = 512,
  parameter int unsigned FRAME_DEPTH = 16,
  parameter int unsigned MAX_BYTES   = 1514,
  parameter int unsigned MIN_BYTES   = 60
) (
  input  logic        dclk,
  input  logic        rst_,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic [31:0] s_axis_tdata,
  input  logic [3:0]  s_axis_tkeep,
  input  logic        s_axis_tlast,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic [3:0]  m_axis_tkeep,
  output logic        m_axis_tlast,
  output logic [15:0] drop_cnt,
  output logic [4:0]  frames_queued
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(FRAME_DEPTH);
  localparam logic [AW:0] RAM_CAP = (AW+1)'(DEPTH);
  localparam logic [LW:0] LEN_CAP = (LW+1)'(FRAME_DEPTH);
  localparam logic [10:0] MAX_LEN = 11'(MAX_BYTES);
  localparam logic [10:0] MIN_LEN = 11'(MIN_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PAD} state_e;

  logic [35:0] ram_q     [DEPTH];
  logic [10:0] len_mem_q [FRAME_DEPTH];

  logic [AW:0] wr_ptr_q, commit_ptr_q, rd_ptr_q;
  logic [LW:0] len_wr_q, len_rd_q;
  logic [10:0] byte_cnt_q;
  logic        bad_q;
  logic        rdy_en_q;
  logic [15:0] drop_q;

  state_e      state_q, state_d;
  logic        m_valid_q, m_valid_d;
  logic [31:0] m_data_q, m_data_d;
  logic [3:0]  m_keep_q, m_keep_d;
  logic        m_last_q, m_last_d;
  logic [10:0] rem_q, rem_d;
  logic [10:0] emit_q, emit_d;
  logic        rd_adv, len_pop;

  // ---------------- write side ----------------
  logic [AW:0] ram_used;
  logic [LW:0] len_used;
  logic        ram_full, len_full, in_fire, over;
  logic [2:0]  kcnt;
  logic [11:0] cnt_sum;
  logic [10:0] cnt_new;

  assign ram_used      = wr_ptr_q - rd_ptr_q;
  assign len_used      = len_wr_q - len_rd_q;
  assign ram_full      = (ram_used == RAM_CAP);
  assign len_full      = (len_used == LEN_CAP);
  assign s_axis_tready = rdy_en_q & ~ram_full & ~len_full;
  assign in_fire       = s_axis_tvalid & s_axis_tready;

  assign kcnt    = {2'b0, s_axis_tkeep[0]} + {2'b0, s_axis_tkeep[1]}
                 + {2'b0, s_axis_tkeep[2]} + {2'b0, s_axis_tkeep[3]};
  assign cnt_sum = {1'b0, byte_cnt_q} + {9'b0, kcnt};
  assign cnt_new = cnt_sum[11] ? 11'h7FF : cnt_sum[10:0];
  assign over    = bad_q | (cnt_new > MAX_LEN);

  always_ff @(posedge dclk) begin
    if (!rst_) begin
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      len_wr_q     <= '0;
      byte_cnt_q   <= '0;
      bad_q        <= 1'b0;
      rdy_en_q     <= 1'b0;
      drop_q       <= '0;
    end else begin
      rdy_en_q <= 1'b1;
      if (in_fire) begin
        if (s_axis_tlast) begin
          byte_cnt_q <= '0;
          bad_q      <= 1'b0;
          if (over) begin
            wr_ptr_q <= commit_ptr_q;
            if (drop_q != '1) drop_q <= drop_q + 16'd1;
          end else begin
            wr_ptr_q     <= wr_ptr_q + 1'b1;
            commit_ptr_q <= wr_ptr_q + 1'b1;
            len_wr_q     <= len_wr_q + 1'b1;
          end
        end else begin
          byte_cnt_q <= cnt_new;
          bad_q      <= over;
          if (!over) wr_ptr_q <= wr_ptr_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge dclk) begin
    if (in_fire && !over) ram_q[wr_ptr_q[AW-1:0]] <= {s_axis_tkeep, s_axis_tdata};
    if (in_fire && !over && s_axis_tlast) len_mem_q[len_wr_q[LW-1:0]] <= cnt_new;
  end

  // ---------------- read side ----------------
  logic [10:0] len_head, ld_rem, ld_emit_n;
  logic [35:0] rd_entry;
  logic [31:0] ld_data;
  logic [3:0]  ld_keep;
  logic        len_empty, ld_last, ld_pad;

  assign len_head  = len_mem_q[len_rd_q[LW-1:0]];
  assign len_empty = (len_wr_q == len_rd_q);
  assign rd_entry  = ram_q[rd_ptr_q[AW-1:0]];

  // Candidate next stored beat; the last beat of a runt is zero-filled to a
  // full word, and only carries tlast if that word already reaches MIN_BYTES.
  always_comb begin
    ld_rem    = (state_q == S_IDLE) ? len_head : rem_q;
    ld_emit_n = ((state_q == S_IDLE) ? 11'd0 : emit_q) + 11'd4;
    ld_data   = rd_entry[31:0];
    ld_keep   = rd_entry[35:32];
    ld_last   = 1'b0;
    ld_pad    = 1'b0;
    if (ld_rem <= 11'd4) begin
      if (len_head >= MIN_LEN) begin
        ld_last = 1'b1;
      end else begin
        ld_data = rd_entry[31:0] & {{8{rd_entry[35]}}, {8{rd_entry[34]}},
                                    {8{rd_entry[33]}}, {8{rd_entry[32]}}};
        ld_keep = 4'hF;
        ld_last = (ld_emit_n >= MIN_LEN);
        ld_pad  = ~ld_last;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_keep_d  = m_keep_q;
    m_last_d  = m_last_q;
    rem_d     = rem_q;
    emit_d    = emit_q;
    rd_adv    = 1'b0;
    len_pop   = 1'b0;
    if ((state_q == S_IDLE && !len_empty) ||
        (state_q == S_DATA && m_axis_tready && !m_last_q)) begin
      m_valid_d = 1'b1;
      m_data_d  = ld_data;
      m_keep_d  = ld_keep;
      m_last_d  = ld_last;
      rem_d     = (ld_rem <= 11'd4) ? 11'd0 : ld_rem - 11'd4;
      emit_d    = ld_emit_n;
      rd_adv    = 1'b1;
      state_d   = ld_pad ? S_PAD : S_DATA;
    end else if (state_q == S_PAD && m_axis_tready && !m_last_q) begin
      m_data_d = '0;
      m_keep_d = '1;
      emit_d   = emit_q + 11'd4;
      m_last_d = (emit_q + 11'd4 >= MIN_LEN);
    end else if (state_q != S_IDLE && m_axis_tready && m_last_q) begin
      state_d   = S_IDLE;
      m_valid_d = 1'b0;
      m_data_d  = '0;
      m_keep_d  = '0;
      m_last_d  = 1'b0;
      len_pop   = 1'b1;
    end
  end

  always_ff @(posedge dclk) begin
    if (!rst_) begin
      state_q   <= S_IDLE;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_keep_q  <= '0;
      m_last_q  <= 1'b0;
      rem_q     <= '0;
      emit_q    <= '0;
      rd_ptr_q  <= '0;
      len_rd_q  <= '0;
    end else begin
      state_q   <= state_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_keep_q  <= m_keep_d;
      m_last_q  <= m_last_d;
      rem_q     <= rem_d;
      emit_q    <= emit_d;
      if (rd_adv)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (len_pop) len_rd_q <= len_rd_q + 1'b1;
    end
  end

  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tkeep  = m_keep_q;
  assign m_axis_tlast  = m_last_q;
  assign drop_cnt      = drop_q;
  assign frames_queued = 5'(len_used);

endmodule

// File: tb/tb_axis_tx_frame_buffer.sv
// Scoreboard bench for axis_tx_frame_buffer: expected beats are queued as
// frames are driven and compared on every output handshake.
module tb_axis_tx_frame_buffer;
  localparam int MIN_B = 60;
  localparam int MAX_B = 1514;

  logic        dclk = 1'b0;
  logic        rst_ = 1'b0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [31:0] s_axis_tdata = '0;
  logic [3:0]  s_axis_tkeep = '0;
  logic        s_axis_tlast = 1'b0;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tlast;
  logic [15:0] drop_cnt;
  logic [4:0]  frames_queued;

  axis_tx_frame_buffer #(.DEPTH(512), .FRAME_DEPTH(16), .MAX_BYTES(MAX_B), .MIN_BYTES(MIN_B)) dut (
    .dclk(dclk), .rst_(rst_),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .drop_cnt(drop_cnt), .frames_queued(frames_queued)
  );

  always #5 dclk = ~dclk;

  int unsigned cyc = 0;
  always @(posedge dclk) cyc <= cyc + 1;

  int          checks = 0;
  int          failures = 0;
  logic [36:0] exp_q[$];
  int          rdy_mode = 1;  // 0: hold low, 1: hold high, 2: random
  int          stall_cnt = 0;
  int unsigned t_in = 0;
  logic        saw_full = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  initial begin
    m_axis_tready = 1'b0;
    forever begin
      @(posedge dclk);
      #1;
      m_axis_tready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
    end
  end

  always @(negedge dclk) begin
    if (rst_ && rdy_mode == 2 && !s_axis_tready) saw_full = 1'b1;
    if (rst_ && m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) check_eq("sb_underflow", 64'(exp_q.size()), 64'd1);
      else check_eq("beat", {27'd0, m_axis_tlast, m_axis_tkeep, m_axis_tdata}, {27'd0, exp_q.pop_front()});
    end
  end

  // Drives a frame of nbytes; abort_beats>0 sends only that many beats, no tlast.
  task automatic send_frame(input int nbytes, input int abort_beats);
    logic [31:0] d[$];
    logic [3:0]  k[$];
    int nb, nsend, rem, w;
    logic ok;
    nb = (nbytes + 3) / 4;
    for (int i = 0; i < nb; i++) begin
      rem = nbytes - 4 * i;
      d.push_back($urandom);
      k.push_back(rem >= 4 ? 4'hF : 4'((1 << rem) - 1));
    end
    if (abort_beats == 0 && nbytes <= MAX_B) begin
      for (int i = 0; i < nb - 1; i++) exp_q.push_back({1'b0, k[i], d[i]});
      if (nbytes >= MIN_B) begin
        exp_q.push_back({1'b1, k[nb-1], d[nb-1]});
      end else begin
        exp_q.push_back({nb >= 15, 4'hF, d[nb-1] & {{8{k[nb-1][3]}}, {8{k[nb-1][2]}},
                                                     {8{k[nb-1][1]}}, {8{k[nb-1][0]}}}});
        for (int j = nb; j < 15; j++) exp_q.push_back({j == 14, 4'hF, 32'h0});
      end
    end
    nsend = (abort_beats != 0) ? abort_beats : nb;
    for (int i = 0; i < nsend; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = d[i];
      s_axis_tkeep  = k[i];
      s_axis_tlast  = (i == nb - 1) && (abort_beats == 0);
      w = 0;
      do begin
        ok = s_axis_tready;
        if (!ok) stall_cnt++;
        if (ok && s_axis_tlast) t_in = cyc;
        @(negedge dclk);
        w++;
      end while (!ok && w < 3000);
      if (!ok) begin
        check_eq("in_accept_timeout", 64'(ok), 64'd1);
        break;
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge dclk);
    check_eq("drain", 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge dclk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge dclk);
    check_eq("rst_s_ready", 64'(s_axis_tready), 64'd0);
    check_eq("rst_m_valid", 64'(m_axis_tvalid), 64'd0);
    check_eq("rst_m_data",  64'(m_axis_tdata), 64'd0);
    check_eq("rst_m_keep",  64'(m_axis_tkeep), 64'd0);
    check_eq("rst_m_last",  64'(m_axis_tlast), 64'd0);
    check_eq("rst_drop",    64'(drop_cnt), 64'd0);
    check_eq("rst_fq",      64'(frames_queued), 64'd0);
    rst_ = 1'b1;
    @(negedge dclk);
    check_eq("post_rst_s_ready", 64'(s_axis_tready), 64'd1);

    // 64B frame, latency from input tlast to first output beat
    send_frame(64, 0);
    n = 0;
    while (!m_axis_tvalid && n < 20) begin @(negedge dclk); n++; end
    check_eq("latency", 64'(cyc - t_in), 64'd2);
    wait_drain(200);

    // 42B runt padded to 60
    send_frame(42, 0);
    wait_drain(200);
    send_frame(57, 0);
    wait_drain(200);

    // oversize then normal frame
    stall_cnt = 0;
    send_frame(1518, 0);
    send_frame(100, 0);
    check_eq("no_input_stall", 64'(stall_cnt), 64'd0);
    wait_drain(1000);
    check_eq("drop_cnt_1", 64'(drop_cnt), 64'd1);
    check_eq("fq_empty", 64'(frames_queued), 64'd0);

    // random backpressure on max-size frames
    rdy_mode = 2;
    saw_full = 1'b0;
    for (int f = 0; f < 5; f++) send_frame(1514, 0);
    wait_drain(20000);
    check_eq("ram_full_seen", 64'(saw_full), 64'd1);
    rdy_mode = 1;
    repeat (3) @(negedge dclk);

    // length FIFO full: 16 frames queued, 17th stalls
    rdy_mode = 0;
    repeat (3) @(negedge dclk);
    for (int f = 0; f < 16; f++) send_frame(64, 0);
    @(negedge dclk);
    check_eq("fq_16", 64'(frames_queued), 64'd16);
    check_eq("stall_17", 64'(s_axis_tready), 64'd0);
    rdy_mode = 1;
    send_frame(64, 0);
    wait_drain(2000);
    check_eq("fq_drained", 64'(frames_queued), 64'd0);

    // reset mid-input
    send_frame(200, 20);
    rst_ = 1'b0;
    @(negedge dclk);
    check_eq("midin_s_ready", 64'(s_axis_tready), 64'd0);
    check_eq("midin_m_valid", 64'(m_axis_tvalid), 64'd0);
    check_eq("midin_fq", 64'(frames_queued), 64'd0);
    rst_ = 1'b1;
    @(negedge dclk);

    // reset mid-output
    rdy_mode = 0;
    send_frame(64, 0);
    repeat (4) @(negedge dclk);
    check_eq("hold_valid", 64'(m_axis_tvalid), 64'd1);
    rst_ = 1'b0;
    @(negedge dclk);
    exp_q.delete();
    check_eq("midout_m_valid", 64'(m_axis_tvalid), 64'd0);
    check_eq("midout_m_data",  64'(m_axis_tdata), 64'd0);
    check_eq("midout_m_keep",  64'(m_axis_tkeep), 64'd0);
    check_eq("midout_m_last",  64'(m_axis_tlast), 64'd0);
    check_eq("midout_drop",    64'(drop_cnt), 64'd0);
    check_eq("midout_fq",      64'(frames_queued), 64'd0);
    rst_ = 1'b1;
    rdy_mode = 1;
    @(negedge dclk);
    send_frame(64, 0);
    wait_drain(200);
    check_eq("final_drop", 64'(drop_cnt), 64'd0);
    check_eq("final_fq", 64'(frames_queued), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
